// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter/sequencer sharing one UART transmitter between NUM_REQ byte requesters.
// Define UART_ARB_FIXED_PRIO_EN to replace round-robin with fixed lowest-index-wins priority.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [1:0]           cfg_char_size,
  input  logic                 cfg_parity_mode,
  input  logic                 cfg_stop_bits,
  input  logic                 cfg_nine_en,
  input  logic                 cfg_nine_bit,
  input  logic                 cfg_rx_en,
  input  logic                 uart_tx_complete,
  output logic [7:0]           uart_cns,
  output logic [7:0]           uart_tx_byte,
  output logic [NUM_REQ-1:0]   grant,
  output logic [NUM_REQ-1:0]   done,
  output logic                 err,
  output logic                 busy
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned TMR_W = $clog2(TIMEOUT);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SEND    = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

  logic [1:0]         state, state_n;
  logic [TMR_W-1:0]   timer, timer_n;
  logic [PTR_W-1:0]   last, last_n;
  logic [PTR_W-1:0]   owner, owner_n;
  logic [NUM_REQ-1:0] grant_n, done_n;
  logic               err_n, busy_n;
  logic [7:0]         tx_byte_n;
  logic [5:0]         cfg_q, cfg_n;
  logic               tx_en, tx_en_n;
  logic               prev_complete;

  logic [PTR_W-1:0]   winner;
  logic               found;
  logic               complete_rise;
  logic               timed_out;
  int unsigned        idx;

  // Winner search; the lowest search offset that finds an active request wins.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
`ifdef UART_ARB_FIXED_PRIO_EN
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      if (req[i]) begin
        winner = PTR_W'(i);
        found  = 1'b1;
      end
    end
`else
    for (int k = int'(NUM_REQ); k >= 1; k--) begin
      idx = (32'(last) + 32'(k)) % NUM_REQ;
      if (req[PTR_W'(idx)]) begin
        winner = PTR_W'(idx);
        found  = 1'b1;
      end
    end
`endif
  end

  assign complete_rise = uart_tx_complete && !prev_complete;
  assign timed_out     = (timer == TMR_W'(TIMEOUT - 1));

  // Next-state and next-output logic.
  always_comb begin
    state_n   = state;
    timer_n   = timer;
    last_n    = last;
    owner_n   = owner;
    grant_n   = grant;
    done_n    = '0;
    err_n     = 1'b0;
    busy_n    = busy;
    tx_byte_n = uart_tx_byte;
    cfg_n     = cfg_q;
    tx_en_n   = tx_en;
    case (state)
      ST_IDLE: begin
        if (found) begin
          state_n   = ST_SEND;
          grant_n   = NUM_REQ'(1) << winner;
          owner_n   = winner;
          tx_byte_n = req_data[{winner, 3'b000} +: 8];
          cfg_n     = {cfg_nine_en, cfg_char_size, cfg_nine_bit, cfg_parity_mode, cfg_stop_bits};
          tx_en_n   = 1'b1;
          timer_n   = '0;
          busy_n    = 1'b1;
        end
      end
      ST_SEND: begin
        timer_n = timer + TMR_W'(1);
        if (complete_rise || timed_out) begin
          state_n = ST_RELEASE;
          tx_en_n = 1'b0;
          grant_n = '0;
          done_n  = NUM_REQ'(1) << owner;
          last_n  = owner;
          err_n   = !complete_rise;
        end
      end
      ST_RELEASE: begin
        state_n = ST_IDLE;
        busy_n  = 1'b0;
      end
      default: begin
        state_n = ST_IDLE;
        grant_n = '0;
        tx_en_n = 1'b0;
        busy_n  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= ST_IDLE;
      timer         <= '0;
      last          <= PTR_W'(NUM_REQ - 1);
      owner         <= '0;
      grant         <= '0;
      done          <= '0;
      err           <= 1'b0;
      busy          <= 1'b0;
      uart_tx_byte  <= '0;
      cfg_q         <= '0;
      tx_en         <= 1'b0;
      prev_complete <= 1'b0;
    end else begin
      state         <= state_n;
      timer         <= timer_n;
      last          <= last_n;
      owner         <= owner_n;
      grant         <= grant_n;
      done          <= done_n;
      err           <= err_n;
      busy          <= busy_n;
      uart_tx_byte  <= tx_byte_n;
      cfg_q         <= cfg_n;
      tx_en         <= tx_en_n;
      prev_complete <= uart_tx_complete;
    end
  end

  // Receiver enable bypasses the latch so the receive side is never gated by arbitration.
  assign uart_cns = {cfg_q, cfg_rx_en, tx_en};

endmodule
